// File: rtl/qlk0rmuldiv1v1_mul_seq_if.sv
// Command/status bus between the MULDIV command issuer plus combinational multiplier (master)
// and the multiply sequencer (slave).
interface qlk0rmuldiv1v1_mul_seq_if;
  logic        start;
  logic [1:0]  op;
  logic        sgn;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        macovf;
  logic [15:0] mula;
  logic [15:0] mulb;
  logic        mdsm;
  logic [31:0] mulo;

  // The master side also hosts the combinational multiplier, so it sources mulo.
  modport master (
    output start, op, sgn, opa, opb, mulo,
    input  busy, done, result, macovf, mula, mulb, mdsm
  );

  modport slave (
    input  start, op, sgn, opa, opb, mulo,
    output busy, done, result, macovf, mula, mulb, mdsm
  );
endinterface

// File: rtl/qlk0rmuldiv1v1_mul_seq.sv
// Sequencer for the MULDIV 16x16 multiplier: MUL/MAC/CLR commands, 32-bit accumulator, sticky overflow.
// Optional build macro MULDIV_MAC_SAT_EN: saturate the accumulator on MAC overflow instead of wrapping.
module qlk0rmuldiv1v1_mul_seq #(
  parameter int WAIT_CYC = 2
) (
  input logic                         i_clk,
  input logic                         i_rst,
  qlk0rmuldiv1v1_mul_seq_if.slave     bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPT} state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYC);
  localparam bit         SHORT  = (WAIT_CYC == 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_mac, w_mac_next;
  logic [31:0] r_acc, w_acc_next;
  logic [31:0] r_result, w_result_next;
  logic        r_done, w_done_next;
  logic        r_macovf, w_macovf_next;
  logic [15:0] r_mula, w_mula_next;
  logic [15:0] r_mulb, w_mulb_next;
  logic        r_mdsm, w_mdsm_next;

  logic [32:0] w_sum;
  logic        w_ovf;
  logic [31:0] w_mac_val;

  assign w_sum = {1'b0, r_acc} + {1'b0, bus.mulo};
  assign w_ovf = r_mdsm ? ((r_acc[31] == bus.mulo[31]) && (w_sum[31] != r_acc[31])) : w_sum[32];

`ifdef MULDIV_MAC_SAT_EN
  // Signed overflow direction follows the shared operand sign.
  assign w_mac_val = !w_ovf  ? w_sum[31:0] :
                     !r_mdsm ? 32'hFFFF_FFFF :
                     r_acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
  assign w_mac_val = w_sum[31:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mac    <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_macovf <= 1'b0;
      r_mula   <= '0;
      r_mulb   <= '0;
      r_mdsm   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_mac    <= w_mac_next;
      r_acc    <= w_acc_next;
      r_result <= w_result_next;
      r_done   <= w_done_next;
      r_macovf <= w_macovf_next;
      r_mula   <= w_mula_next;
      r_mulb   <= w_mulb_next;
      r_mdsm   <= w_mdsm_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_mac_next    = r_mac;
    w_acc_next    = r_acc;
    w_result_next = r_result;
    w_done_next   = 1'b0;
    w_macovf_next = r_macovf;
    w_mula_next   = r_mula;
    w_mulb_next   = r_mulb;
    w_mdsm_next   = r_mdsm;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MUL, OP_MAC: begin
              w_mula_next  = bus.opa;
              w_mulb_next  = bus.opb;
              w_mdsm_next  = bus.sgn;
              w_mac_next   = (bus.op == OP_MAC);
              w_cnt_next   = C_WAIT;
              w_state_next = SHORT ? ST_CAPT : ST_WAIT;
            end
            OP_CLR: begin
              w_acc_next    = '0;
              w_macovf_next = 1'b0;
              w_result_next = '0;
              w_done_next   = 1'b1;
            end
            default: w_done_next = 1'b1;
          endcase
        end
      end
      ST_WAIT: begin
        // CAPT is the last settle cycle, so leave WAIT one count early.
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd2) w_state_next = ST_CAPT;
      end
      ST_CAPT: begin
        if (r_mac) begin
          w_acc_next    = w_mac_val;
          w_result_next = w_mac_val;
          if (w_ovf) w_macovf_next = 1'b1;
        end else begin
          w_result_next = bus.mulo;
        end
        w_done_next  = 1'b1;
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.macovf = r_macovf;
  assign bus.mula   = r_mula;
  assign bus.mulb   = r_mulb;
  assign bus.mdsm   = r_mdsm;

endmodule

// File: tb/tb_qlk0rmuldiv1v1_mul_seq.sv
// Bench for qlk0rmuldiv1v1_mul_seq: directed cases plus random commands against an arithmetic model.
module tb_qlk0rmuldiv1v1_mul_seq;
  localparam int WAIT_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qlk0rmuldiv1v1_mul_seq_if bus();

  qlk0rmuldiv1v1_mul_seq #(.WAIT_CYC(WAIT_CYC)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Combinational multiplier driven by the registered operands.
  always_comb begin
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = $signed(bus.mula);
    sb = $signed(bus.mulb);
    if (bus.mdsm) bus.mulo = sa * sb;
    else          bus.mulo = {16'b0, bus.mula} * {16'b0, bus.mulb};
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_acc;
  logic [31:0] m_result;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic sgn, input logic [15:0] a,
                       input logic [15:0] b, output int exp_lat);
    longint p, s, hi, lo;
    logic [31:0] p32, val;
    logic ovf;
    hi = 2147483647;
    lo = -hi - 1;
    exp_lat = 1;
    if (op == 2'd0 || op == 2'd1) begin
      exp_lat = WAIT_CYC + 1;
      if (sgn) p = longint'($signed(a)) * longint'($signed(b));
      else     p = longint'(a) * longint'(b);
      p32 = p[31:0];
      if (op == 2'd0) begin
        m_result = p32;
      end else begin
        if (sgn) begin
          s   = longint'($signed(m_acc)) + longint'($signed(p32));
          ovf = (s > hi) || (s < lo);
        end else begin
          s   = longint'(m_acc) + longint'(p32);
          ovf = (s >= (longint'(1) << 32));
        end
        val = s[31:0];
`ifdef MULDIV_MAC_SAT_EN
        if (ovf) val = !sgn ? 32'hFFFF_FFFF : (s > hi) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        m_acc    = val;
        m_result = val;
        if (ovf) m_ovf = 1'b1;
      end
    end else if (op == 2'd2) begin
      m_acc    = '0;
      m_result = '0;
      m_ovf    = 1'b0;
    end
  endtask

  // Issue one command in the current cycle and return in its DONE cycle (sampled #1 after the edge).
  task automatic cmd(input string tag, input logic [1:0] op, input logic sgn,
                     input logic [15:0] a, input logic [15:0] b);
    int exp_lat;
    int lat;
    model(op, sgn, a, b, exp_lat);
    bus.start = 1'b1; bus.op = op; bus.sgn = sgn; bus.opa = a; bus.opb = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.sgn = 1'($urandom);
    bus.opa = 16'($urandom); bus.opb = 16'($urandom);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.done) begin
        lat = n;
        break;
      end
      if (op < 2'd2) begin
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_mula"}, 32'(bus.mula), 32'(a));
        chk({tag, "_mdsm"}, 32'(bus.mdsm), 32'(sgn));
      end
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, bus.result, m_result);
    chk({tag, "_macovf"}, 32'(bus.macovf), 32'(m_ovf));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    $display("txn %s op=%0d sgn=%0d a=%h b=%h result=%h macovf=%0d lat=%0d",
             tag, op, sgn, a, b, bus.result, bus.macovf, lat);
  endtask

  initial begin
    int exp_lat, ndone, first;
    logic [1:0] rop;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.sgn = 1'b0; bus.opa = '0; bus.opb = '0;
    m_acc = '0; m_result = '0; m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_result", bus.result,      32'd0);
    chk("rst_macovf", 32'(bus.macovf), 32'd0);
    chk("rst_mula",   32'(bus.mula),   32'd0);
    chk("rst_mulb",   32'(bus.mulb),   32'd0);
    chk("rst_mdsm",   32'(bus.mdsm),   32'd0);

    cmd("t1_mul_u", 2'd0, 1'b0, 16'hFFFF, 16'hFFFF);
    chk("t1_const", bus.result, 32'hFFFE_0001);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(bus.done), 32'd0);
    chk("t1_hold", bus.result, 32'hFFFE_0001);

    cmd("t2_mul_s", 2'd0, 1'b1, 16'hFFFF, 16'h0002);
    chk("t2_const", bus.result, 32'hFFFF_FFFE);

    cmd("t3_clr", 2'd2, 1'b0, 16'h0, 16'h0);
    cmd("t3_mac1", 2'd1, 1'b0, 16'h0003, 16'h0004);
    chk("t3_c1", bus.result, 32'h0000_000C);
    cmd("t3_mac2", 2'd1, 1'b0, 16'h0003, 16'h0004);
    chk("t3_c2", bus.result, 32'h0000_0018);

    cmd("t4_clr", 2'd2, 1'b0, 16'h0, 16'h0);
    cmd("t4_mac1", 2'd1, 1'b1, 16'h7FFF, 16'h7FFF);
    chk("t4_c1", bus.result, 32'h3FFF_0001);
    cmd("t4_mac2", 2'd1, 1'b1, 16'h7FFF, 16'h7FFF);
    chk("t4_c2", bus.result, 32'h7FFE_0002);
    cmd("t4_mac3", 2'd1, 1'b1, 16'h7FFF, 16'h7FFF);
`ifdef MULDIV_MAC_SAT_EN
    chk("t4_c3", bus.result, 32'h7FFF_FFFF);
`else
    chk("t4_c3", bus.result, 32'hBFFD_0003);
`endif
    chk("t4_ovf", 32'(bus.macovf), 32'd1);
    cmd("t4_res", 2'd3, 1'b0, 16'h1234, 16'h5678);
    cmd("t4_clr2", 2'd2, 1'b0, 16'h0, 16'h0);
    chk("t4_ovf_clr", 32'(bus.macovf), 32'd0);

    // Back-to-back: each cmd returns in the DONE cycle and the next starts there.
    cmd("t6_a", 2'd0, 1'b0, 16'h0100, 16'h0010);
    cmd("t6_b", 2'd0, 1'b0, 16'h0007, 16'h0009);

    // START pulsed while busy must be dropped.
    model(2'd0, 1'b0, 16'd5, 16'd7, exp_lat);
    bus.start = 1'b1; bus.op = 2'd0; bus.sgn = 1'b0; bus.opa = 16'd5; bus.opb = 16'd7;
    @(posedge clk); #1;
    bus.op = 2'd2; bus.opa = 16'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; first = 0;
    for (int n = 2; n <= 12; n++) begin
      if (bus.done) begin
        ndone++;
        if (first == 0) first = n;
      end
      @(posedge clk); #1;
    end
    chk("t5_ndone", 32'(ndone), 32'd1);
    chk("t5_lat", 32'(first), 32'(exp_lat));
    chk("t5_result", bus.result, 32'd35);
    $display("txn t5_ignore result=%h dones=%0d lat=%0d", bus.result, ndone, first);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) rop = 2'd1;
      cmd($sformatf("rnd%0d", i), rop, 1'($urandom), 16'($urandom), 16'($urandom));
    end

    // Reset in the middle of a command: aborted, no DONE, everything cleared.
    cmd("t5_pre", 2'd0, 1'b0, 16'h00FF, 16'h0003);
    bus.start = 1'b1; bus.op = 2'd1; bus.sgn = 1'b0; bus.opa = 16'h1111; bus.opb = 16'h2222;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5r_busy",   32'(bus.busy),   32'd0);
    chk("t5r_result", bus.result,      32'd0);
    chk("t5r_macovf", 32'(bus.macovf), 32'd0);
    chk("t5r_mula",   32'(bus.mula),   32'd0);
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      if (bus.done) ndone++;
      @(posedge clk); #1;
    end
    chk("t5r_nodone", 32'(ndone), 32'd0);
    $display("txn t5_rst result=%h dones=%0d", bus.result, ndone);
    m_acc = '0; m_result = '0; m_ovf = 1'b0;
    cmd("post_rst_mac", 2'd1, 1'b0, 16'h0002, 16'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
